if_id_flush_reg: RTL and testbench



---
 rtl/if_id_flush_reg.sv | 125 ++++++++++++
 tb/tb_if_id_flush_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_flush_reg.sv
// IF/ID pipeline register with flush handling.
// Holds the fetched PC/instruction for decode. On a flush the contents become
// a NOP bubble, and the next KILL_CYCLES fetch returns are dropped because
// they were already in flight on the wrong path. Every valid instruction
// dropped this way bumps a saturating squash counter.
//
// Control priority on each edge: reset > flush > stall > KILL > IDLE load.
// Decode accepts pc_out/instr_out whenever valid_out=1 and stall=0. stall
// freezes the register, and fetch is held by the same stall. For that reason
// instr_valid_in is ignored while stall=1.
//
// KILL_CYCLES must lie in 0..7 because kill_cnt is 3 bits wide.
module if_id_flush_reg #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] NOP_INSTR   = 32'h00000013,
  parameter int unsigned     KILL_CYCLES = 1,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  instr_in,
  input  logic             instr_valid_in,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  instr_out,
  output logic             valid_out,
  output logic             kill_active,
  output logic [CNT_W-1:0] squash_count
);

  typedef enum logic {
    IDLE = 1'b0,
    KILL = 1'b1
  } state_t;

  localparam logic [2:0]       KILL_INIT = 3'(KILL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [2:0]       kill_cnt_q, kill_cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic [1:0]       sq_inc;
  logic [CNT_W:0]   sq_sum;

  // Next-state selection for the register contents and the kill FSM.
  always_comb begin
    state_d    = state_q;
    kill_cnt_d = kill_cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    sq_inc     = 2'd0;

    if (flush) begin
      // Both the current occupant and the instruction arriving now are on
      // the wrong path, so either can be discarded by this flush.
      pc_d    = pc_in;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      sq_inc  = {1'b0, valid_q} + {1'b0, instr_valid_in};
      if (KILL_CYCLES > 0) begin
        state_d    = KILL;
        kill_cnt_d = KILL_INIT;
      end else begin
        state_d    = IDLE;
        kill_cnt_d = 3'd0;
      end
    end else if (stall) begin
      // Hold everything. Fetch is frozen too, so its valid bit means nothing.
    end else if (state_q == KILL) begin
      // Still draining returns from before the flush. Each unstalled cycle
      // consumes one kill slot whether or not a return shows up.
      pc_d       = pc_in;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      sq_inc     = {1'b0, instr_valid_in};
      kill_cnt_d = kill_cnt_q - 3'd1;
      if (kill_cnt_q <= 3'd1) begin
        state_d    = IDLE;
        kill_cnt_d = 3'd0;
      end
    end else begin
      pc_d    = pc_in;
      valid_d = instr_valid_in;
      instr_d = instr_valid_in ? instr_in : NOP_INSTR;
    end
  end

  // Saturating add. The carry out of the widened sum means we passed all-ones.
  always_comb begin
    sq_sum   = {1'b0, squash_q} + (CNT_W + 1)'(sq_inc);
    squash_d = sq_sum[CNT_W] ? CNT_MAX : sq_sum[CNT_W-1:0];
  end

  // State and output registers; reset takes effect immediately, even mid-KILL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kill_cnt_q <= 3'd0;
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      squash_q   <= '0;
    end else begin
      state_q    <= state_d;
      kill_cnt_q <= kill_cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      squash_q   <= squash_d;
    end
  end

  assign pc_out       = pc_q;
  assign instr_out    = instr_q;
  assign valid_out    = valid_q;
  assign kill_active  = (state_q == KILL);
  assign squash_count = squash_q;

endmodule

// File: tb/tb_if_id_flush_reg.sv
// Bench for if_id_flush_reg: three builds (KILL_CYCLES 1/3/0) share fetch-side
// inputs, and each build has its own flush line.
module tb_if_id_flush_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall, iv;
  logic        flush_a, flush_b, flush_c;
  logic [31:0] pc_in, instr_in;

  logic [31:0] pc_a, ins_a, pc_b, ins_b, pc_c, ins_c;
  logic        v_a, k_a, v_b, k_b, v_c, k_c;
  logic [15:0] sq_a;
  logic [3:0]  sq_b, sq_c;

  if_id_flush_reg #(.XLEN(32), .NOP_INSTR(NOP), .KILL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .stall(stall), .pc_in(pc_in),
    .instr_in(instr_in), .instr_valid_in(iv), .pc_out(pc_a), .instr_out(ins_a),
    .valid_out(v_a), .kill_active(k_a), .squash_count(sq_a));

  if_id_flush_reg #(.XLEN(32), .NOP_INSTR(NOP), .KILL_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .stall(stall), .pc_in(pc_in),
    .instr_in(instr_in), .instr_valid_in(iv), .pc_out(pc_b), .instr_out(ins_b),
    .valid_out(v_b), .kill_active(k_b), .squash_count(sq_b));

  if_id_flush_reg #(.XLEN(32), .NOP_INSTR(NOP), .KILL_CYCLES(0), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(flush_c), .stall(stall), .pc_in(pc_in),
    .instr_in(instr_in), .instr_valid_in(iv), .pc_out(pc_c), .instr_out(ins_c),
    .valid_out(v_c), .kill_active(k_c), .squash_count(sq_c));

  // ---------------- scoreboard counters ----------------
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [31:0] ins_of(input logic [31:0] p);
    return 32'hA500_0000 ^ p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input logic [31:0] e_pc, input logic e_v,
                       input logic e_k, input logic [15:0] e_sq);
    chk({n, " a.pc"}, pc_a, e_pc);
    chk({n, " a.instr"}, ins_a, e_v ? ins_of(e_pc) : NOP);
    chk({n, " a.valid"}, 32'(v_a), 32'(e_v));
    chk({n, " a.kill"}, 32'(k_a), 32'(e_k));
    chk({n, " a.squash"}, 32'(sq_a), 32'(e_sq));
  endtask

  task automatic chk_b(input string n, input logic [31:0] e_pc, input logic e_v,
                       input logic e_k, input logic [3:0] e_sq);
    chk({n, " b.pc"}, pc_b, e_pc);
    chk({n, " b.instr"}, ins_b, e_v ? ins_of(e_pc) : NOP);
    chk({n, " b.valid"}, 32'(v_b), 32'(e_v));
    chk({n, " b.kill"}, 32'(k_b), 32'(e_k));
    chk({n, " b.squash"}, 32'(sq_b), 32'(e_sq));
  endtask

  task automatic chk_c(input string n, input logic [31:0] e_pc, input logic e_v,
                       input logic e_k, input logic [3:0] e_sq);
    chk({n, " c.pc"}, pc_c, e_pc);
    chk({n, " c.instr"}, ins_c, e_v ? ins_of(e_pc) : NOP);
    chk({n, " c.valid"}, 32'(v_c), 32'(e_v));
    chk({n, " c.kill"}, 32'(k_c), 32'(e_k));
    chk({n, " c.squash"}, 32'(sq_c), 32'(e_sq));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fa, input logic fb, input logic fc, input logic st,
                       input logic v, input logic [31:0] p);
    flush_a  = fa;
    flush_b  = fb;
    flush_c  = fc;
    stall    = st;
    iv       = v;
    pc_in    = p;
    instr_in = ins_of(p);
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- vector table for the KILL_CYCLES=1 build ----------------
  typedef struct {
    logic        fl, st, v;
    logic [31:0] pc;
    logic [31:0] e_pc;
    logic        e_v, e_k;
    logic [15:0] e_sq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic fl, input logic st, input logic v,
                              input logic [31:0] pc, input logic [31:0] e_pc,
                              input logic e_v, input logic e_k, input logic [15:0] e_sq);
    vec_t r;
    r.fl = fl; r.st = st; r.v = v; r.pc = pc;
    r.e_pc = e_pc; r.e_v = e_v; r.e_k = e_k; r.e_sq = e_sq;
    return r;
  endfunction

  initial begin
    //                fl st iv  pc          exp_pc      v  k  sq
    vt.push_back(mk(0, 0, 1, 32'h100, 32'h100, 1, 0, 0));  // normal flow
    vt.push_back(mk(0, 0, 1, 32'h104, 32'h104, 1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h200, 32'h104, 1, 0, 0));  // stall x3 freezes
    vt.push_back(mk(0, 1, 1, 32'h204, 32'h104, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'h208, 32'h104, 1, 0, 0));
    vt.push_back(mk(1, 1, 1, 32'h108, 32'h108, 0, 1, 2));  // flush beats stall, +2
    vt.push_back(mk(0, 0, 1, 32'h10C, 32'h10C, 0, 0, 3));  // killed return, +1
    vt.push_back(mk(0, 0, 1, 32'h120, 32'h120, 1, 0, 3));  // loading resumes
    vt.push_back(mk(0, 0, 0, 32'h124, 32'h124, 0, 0, 3));  // invalid fetch -> NOP
    vt.push_back(mk(1, 0, 0, 32'h128, 32'h128, 0, 1, 3));  // flush, nothing to count
    vt.push_back(mk(1, 0, 1, 32'h12C, 32'h12C, 0, 1, 4));  // back-to-back flush reloads
    vt.push_back(mk(0, 0, 0, 32'h130, 32'h130, 0, 0, 4));  // one KILL cycle after 2nd
    vt.push_back(mk(0, 0, 1, 32'h134, 32'h134, 1, 0, 4));
    vt.push_back(mk(1, 0, 0, 32'h138, 32'h138, 0, 1, 5));  // flush valid occupant, +1
    vt.push_back(mk(0, 1, 1, 32'h13C, 32'h138, 0, 1, 5));  // stall in KILL: hold, no count
    vt.push_back(mk(0, 0, 0, 32'h140, 32'h140, 0, 0, 5));
    vt.push_back(mk(0, 0, 1, 32'h144, 32'h144, 1, 0, 5));

    do_reset();
    chk_a("reset", 32'h0, 0, 0, 16'd0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].fl, 0, 0, vt[i].st, vt[i].v, vt[i].pc);
      step();
      chk_a($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_v, vt[i].e_k, vt[i].e_sq);
    end

    // Async reset between edges while in KILL.
    drive(1, 0, 0, 0, 1, 32'h150);
    step();
    chk_a("pre_async", 32'h150, 0, 1, 16'd7);
    drive(0, 0, 0, 0, 0, 32'h154);
    #2 reset = 1'b1;
    #1 chk_a("async_reset", 32'h0, 0, 0, 16'd0);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h160);
    step();
    chk_a("after_async", 32'h160, 1, 0, 16'd0);

    // ---- KILL_CYCLES=3: stall during KILL, then exactly 3 bubbles ----
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h200);
    step();
    chk_b("b_flush", 32'h200, 0, 1, 4'd0);
    for (int j = 0; j < 2; j++) begin
      drive(0, 0, 0, 1, 1, 32'h204);
      step();
      chk_b($sformatf("b_stall%0d", j), 32'h200, 0, 1, 4'd0);
    end
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 0, 1, 32'h210 + 32'(4 * j));
      step();
      chk_b($sformatf("b_kill%0d", j), 32'h210 + 32'(4 * j), 0, (j < 2), 4'(j + 1));
    end
    drive(0, 0, 0, 0, 1, 32'h220);
    step();
    chk_b("b_resume", 32'h220, 1, 0, 4'd3);

    // ---- saturation on the 4-bit counter ----
    drive(0, 1, 0, 0, 1, 32'h224);
    step();
    chk_b("b_sat_flush0", 32'h224, 0, 1, 4'd5);
    for (int j = 0; j < 9; j++) begin
      drive(0, 1, 0, 0, 1, 32'h228 + 32'(4 * j));
      step();
      chk_b($sformatf("b_sat_ramp%0d", j), 32'h228 + 32'(4 * j), 0, 1, 4'(6 + j));
    end
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 0, 0, 32'h230 + 32'(4 * j));
      step();
      chk_b($sformatf("b_drain%0d", j), 32'h230 + 32'(4 * j), 0, (j < 2), 4'd14);
    end
    drive(0, 0, 0, 0, 1, 32'h240);
    step();
    chk_b("b_load14", 32'h240, 1, 0, 4'd14);
    drive(0, 1, 0, 0, 1, 32'h244);
    step();
    chk_b("b_sat_plus2", 32'h244, 0, 1, 4'd15);
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 0, 0, 1, 32'h248 + 32'(4 * j));
      step();
      chk_b($sformatf("b_sat_hold%0d", j), 32'h248 + 32'(4 * j), 0, 1, 4'd15);
    end

    // ---- KILL_CYCLES=0: one bubble, never KILL ----
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h300);
    step();
    chk_c("c_load", 32'h300, 1, 0, 4'd0);
    drive(0, 0, 1, 0, 1, 32'h304);
    step();
    chk_c("c_flush", 32'h304, 0, 0, 4'd2);
    drive(0, 0, 0, 0, 1, 32'h308);
    step();
    chk_c("c_resume", 32'h308, 1, 0, 4'd2);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
